// File: rtl/elbeth_mem_arbiter_pkg.sv
// Shared encodings for the elbeth single-port memory arbiter.
package elbeth_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_GRANT_I = 3'd1,
    ARB_GRANT_D = 3'd2,
    ARB_DONE_I  = 3'd3,
    ARB_DONE_D  = 3'd4
  } arb_state_t;

  localparam logic [3:0] RW_READ = 4'b0000;

endpackage

// File: rtl/elbeth_arb_prio.sv
// Data-first priority pick with a starvation counter that forces an
// instruction grant after MAX_D_BURST back-to-back data grants.
module elbeth_arb_prio #(
  parameter int MAX_D_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic imem_en,
  input  logic dmem_en,
  input  logic grant_take,
  output logic pick_d
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_D_BURST);

  logic [3:0] starve_cnt;

  assign pick_d = dmem_en && !(imem_en && starve_cnt == BURST_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_take) begin
      if (!pick_d)
        starve_cnt <= '0;
      else if (imem_en && starve_cnt != BURST_MAX)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/elbeth_mem_arbiter.sv
// Shares one single-port memory between the core's imem and dmem ports:
// capture on grant, one memory access, a DONE bubble with the ready pulse.
module elbeth_mem_arbiter
  import elbeth_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_en,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic [3:0]        imem_rw,
  input  logic [DATA_W-1:0] imem_wdata,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_ready,
  output logic              imem_error,
  input  logic              dmem_en,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [3:0]        dmem_rw,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_ready,
  output logic              dmem_error,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_rw,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              mem_error
);

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  arb_state_t        state;
  logic [ADDR_W-1:0] cap_addr;
  logic [3:0]        cap_rw;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] cap_rdata;
  logic              cap_err;
  logic [7:0]        wd_cnt;
  logic              pick_d;
  logic              grant_take;
  logic              grant;

  assign grant_take = (state == ARB_IDLE) && (imem_en || dmem_en);

  elbeth_arb_prio #(.MAX_D_BURST(MAX_D_BURST)) u_prio (
    .clk       (clk),
    .rst       (rst),
    .imem_en   (imem_en),
    .dmem_en   (dmem_en),
    .grant_take(grant_take),
    .pick_d    (pick_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      cap_addr  <= '0;
      cap_rw    <= RW_READ;
      cap_wdata <= '0;
      cap_rdata <= '0;
      cap_err   <= 1'b0;
      wd_cnt    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          wd_cnt <= '0;
          if (pick_d) begin
            cap_addr  <= dmem_addr;
            cap_rw    <= dmem_rw;
            cap_wdata <= dmem_wdata;
            state     <= ARB_GRANT_D;
          end else if (imem_en) begin
            cap_addr  <= imem_addr;
            cap_rw    <= imem_rw;
            cap_wdata <= imem_wdata;
            state     <= ARB_GRANT_I;
          end
        end
        ARB_GRANT_I, ARB_GRANT_D: begin
          // Watchdog abort completes the access with error and zero data
          if (mem_ready) begin
            cap_rdata <= mem_rdata;
            cap_err   <= mem_error;
            wd_cnt    <= '0;
            state     <= (state == ARB_GRANT_I) ? ARB_DONE_I : ARB_DONE_D;
          end else if (wd_cnt == WD_LAST) begin
            cap_rdata <= '0;
            cap_err   <= 1'b1;
            wd_cnt    <= '0;
            state     <= (state == ARB_GRANT_I) ? ARB_DONE_I : ARB_DONE_D;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign grant      = (state == ARB_GRANT_I) || (state == ARB_GRANT_D);
  assign mem_en     = grant;
  assign mem_addr   = grant ? cap_addr  : '0;
  assign mem_rw     = grant ? cap_rw    : '0;
  assign mem_wdata  = grant ? cap_wdata : '0;

  assign imem_ready = (state == ARB_DONE_I);
  assign imem_rdata = imem_ready ? cap_rdata : '0;
  assign imem_error = imem_ready && cap_err;
  assign dmem_ready = (state == ARB_DONE_D);
  assign dmem_rdata = dmem_ready ? cap_rdata : '0;
  assign dmem_error = dmem_ready && cap_err;

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// Directed bench: a cycle table for the basic flows plus hand sequences for
// starvation, watchdog timeout and reset mid-access.
module tb_elbeth_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en, dmem_en;
  logic [7:0]  imem_addr, dmem_addr;
  logic [3:0]  imem_rw, dmem_rw;
  logic [31:0] imem_wdata, dmem_wdata;
  logic [31:0] imem_rdata, dmem_rdata;
  logic        imem_ready, imem_error, dmem_ready, dmem_error;
  logic        mem_en;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_rw;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready, mem_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elbeth_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_D_BURST(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rw(imem_rw), .imem_wdata(imem_wdata),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .imem_error(imem_error),
    .dmem_en(dmem_en), .dmem_addr(dmem_addr), .dmem_rw(dmem_rw), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .dmem_error(dmem_error),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_error(mem_error)
  );

  typedef struct {
    logic         i_en;
    logic [7:0]   i_addr;
    logic         d_en;
    logic [7:0]   d_addr;
    logic [3:0]   d_rw;
    logic [31:0]  d_wdata;
    logic         m_rdy;
    logic         m_err;
    logic [31:0]  m_rdata;
    logic [112:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [112:0] eg(input logic [7:0] a, input logic [3:0] rw, input logic [31:0] wd);
    return {1'b1, a, rw, wd, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
  endfunction

  function automatic logic [112:0] ei(input logic err, input logic [31:0] rd);
    return {1'b0, 8'h0, 4'h0, 32'h0, 1'b1, err, rd, 1'b0, 1'b0, 32'h0};
  endfunction

  function automatic logic [112:0] ed(input logic err, input logic [31:0] rd);
    return {1'b0, 8'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, err, rd};
  endfunction

  function automatic vec_t mk(input logic ie, input logic [7:0] ia, input logic de,
                              input logic [7:0] da, input logic [3:0] drw, input logic [31:0] dwd,
                              input logic mr, input logic me, input logic [31:0] mrd,
                              input logic [112:0] e);
    vec_t v;
    v.i_en = ie; v.i_addr = ia; v.d_en = de; v.d_addr = da; v.d_rw = drw; v.d_wdata = dwd;
    v.m_rdy = mr; v.m_err = me; v.m_rdata = mrd; v.exp = e;
    return v;
  endfunction

  function automatic logic [112:0] outs();
    return {mem_en, mem_addr, mem_rw, mem_wdata, imem_ready, imem_error, imem_rdata,
            dmem_ready, dmem_error, dmem_rdata};
  endfunction

  initial begin
    logic [112:0] e0;
    logic [7:0]   gaddr[6];
    logic [7:0]   gexp[6];
    int n, c, g, pulses;
    logic seen, terr;
    logic [31:0] trd;

    e0 = '0;
    // single read, simultaneous D/I, memory error, stray mem_ready in IDLE
    vecs[0]  = mk(1, 8'h10, 0, 8'h00, 4'h0, 32'h0,        0, 0, 32'h0,        e0);
    vecs[1]  = mk(1, 8'h10, 0, 8'h00, 4'h0, 32'h0,        0, 0, 32'h0,        eg(8'h10, 4'h0, 32'h0));
    vecs[2]  = mk(1, 8'h10, 0, 8'h00, 4'h0, 32'h0,        1, 0, 32'hDEADBEEF, eg(8'h10, 4'h0, 32'h0));
    vecs[3]  = mk(0, 8'h10, 0, 8'h00, 4'h0, 32'h0,        0, 0, 32'h0,        ei(0, 32'hDEADBEEF));
    vecs[4]  = mk(0, 8'h00, 0, 8'h00, 4'h0, 32'h0,        0, 0, 32'h0,        e0);
    vecs[5]  = mk(1, 8'h30, 1, 8'h20, 4'hF, 32'h12345678, 0, 0, 32'h0,        e0);
    vecs[6]  = mk(1, 8'h30, 1, 8'h20, 4'hF, 32'h12345678, 0, 0, 32'h0,        eg(8'h20, 4'hF, 32'h12345678));
    vecs[7]  = mk(1, 8'h30, 1, 8'h20, 4'hF, 32'h12345678, 1, 0, 32'hA5A5A5A5, eg(8'h20, 4'hF, 32'h12345678));
    vecs[8]  = mk(1, 8'h30, 0, 8'h00, 4'h0, 32'h0,        0, 0, 32'h0,        ed(0, 32'hA5A5A5A5));
    vecs[9]  = mk(1, 8'h30, 0, 8'h00, 4'h0, 32'h0,        0, 0, 32'h0,        e0);
    vecs[10] = mk(1, 8'h30, 0, 8'h00, 4'h0, 32'h0,        0, 0, 32'h0,        eg(8'h30, 4'h0, 32'h0));
    vecs[11] = mk(1, 8'h30, 0, 8'h00, 4'h0, 32'h0,        1, 1, 32'h0BADF00D, eg(8'h30, 4'h0, 32'h0));
    vecs[12] = mk(0, 8'h00, 0, 8'h00, 4'h0, 32'h0,        0, 0, 32'h0,        ei(1, 32'h0BADF00D));
    vecs[13] = mk(0, 8'h00, 0, 8'h00, 4'h0, 32'h0,        0, 0, 32'h0,        e0);
    vecs[14] = mk(0, 8'h00, 0, 8'h00, 4'h0, 32'h0,        1, 1, 32'h11111111, e0);
    vecs[15] = mk(0, 8'h00, 0, 8'h00, 4'h0, 32'h0,        0, 0, 32'h0,        e0);

    rst = 1'b1;
    imem_en = 0; imem_addr = 0; imem_rw = 0; imem_wdata = 0;
    dmem_en = 0; dmem_addr = 0; dmem_rw = 0; dmem_wdata = 0;
    mem_rdata = 0; mem_ready = 0; mem_error = 0;
    step(); step();
    chk("reset_outputs", 128'(outs()), 128'(e0));
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      imem_en = vecs[i].i_en; imem_addr = vecs[i].i_addr;
      dmem_en = vecs[i].d_en; dmem_addr = vecs[i].d_addr;
      dmem_rw = vecs[i].d_rw; dmem_wdata = vecs[i].d_wdata;
      mem_ready = vecs[i].m_rdy; mem_error = vecs[i].m_err; mem_rdata = vecs[i].m_rdata;
      #1;
      chk($sformatf("vec%0d", i), 128'(outs()), 128'(vecs[i].exp));
      step();
    end

    // starvation: both held, memory answers in the first grant cycle
    imem_en = 1; imem_addr = 8'h30; dmem_en = 1; dmem_addr = 8'h20; dmem_rw = 0; dmem_wdata = 0;
    mem_error = 0; mem_rdata = 0;
    gexp[0] = 8'h20; gexp[1] = 8'h20; gexp[2] = 8'h20; gexp[3] = 8'h20; gexp[4] = 8'h30; gexp[5] = 8'h20;
    n = 0;
    for (c = 0; c < 60 && n < 6; c++) begin
      mem_ready = mem_en;
      #1;
      if (mem_en) begin gaddr[n] = mem_addr; n++; end
      step();
    end
    chk("starve_grant_count", 128'(n), 128'(6));
    for (int i = 0; i < n; i++) chk($sformatf("starve_grant%0d", i), 128'(gaddr[i]), 128'(gexp[i]));
    imem_en = 0; dmem_en = 0; mem_ready = 0;
    step(); step();

    // watchdog: memory never answers
    dmem_en = 1; dmem_addr = 8'h44; mem_rdata = 32'hFFFFFFFF;
    g = 0; seen = 0; terr = 0; trd = 32'h1;
    for (c = 0; c < 40 && !seen; c++) begin
      #1;
      if (mem_en) g++;
      if (dmem_ready) begin seen = 1; terr = dmem_error; trd = dmem_rdata; end
      step();
    end
    chk("timeout_ready_seen", 128'(seen), 128'(1));
    chk("timeout_grant_cycles", 128'(g), 128'(16));
    chk("timeout_error", 128'(terr), 128'(1));
    chk("timeout_rdata", 128'(trd), 128'(0));
    dmem_en = 0; mem_rdata = 0;
    step();

    // reset during GRANT_I abandons the access
    imem_en = 1; imem_addr = 8'h50;
    step();
    #1;
    chk("rst_grant_entered", 128'(mem_en), 128'(1));
    rst = 1;
    step();
    #1;
    chk("rst_mem_en_low", 128'({mem_en, imem_ready}), 128'(0));
    rst = 0; imem_en = 0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      #1;
      if (imem_ready || mem_en) pulses++;
    end
    chk("rst_no_ready_pulse", 128'(pulses), 128'(0));

    imem_en = 1; imem_addr = 8'h54; mem_rdata = 32'hCAFEF00D;
    seen = 0; trd = 0; g = 0;
    for (c = 0; c < 20 && !seen; c++) begin
      mem_ready = mem_en;
      #1;
      if (mem_en && mem_addr == 8'h54) g++;
      if (imem_ready) begin seen = 1; trd = imem_rdata; imem_en = 0; end
      step();
    end
    chk("rst_fresh_served", 128'({seen, g[7:0]}), 128'({1'b1, 8'd1}));
    chk("rst_fresh_rdata", 128'(trd), 128'(32'hCAFEF00D));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
